// File: rtl/bios_arb_pkg.sv
// Shared definitions for the BIOS memory port arbiter: FSM encoding and
// default address/data widths.
package bios_arb_pkg;

   localparam int ARB_ADDR_W = 11;
   localparam int ARB_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_RESP = 2'd2
   } arb_state_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick with an optional lock mask that restricts the
// choice to the lock holder.
module arb_rr2 (
   input  logic [1:0] i_req,
   input  logic       i_lock_en,
   input  logic       i_lock_id,
   input  logic       i_last,
   output logic       o_gnt_vld,
   output logic       o_gnt_id
);

   logic [1:0] w_elig;

   // Mask requests by lock, then prefer the requester not granted last on a tie
   always_comb begin
      w_elig = i_req;
      if (i_lock_en) begin
         w_elig = i_req & (i_lock_id ? 2'b10 : 2'b01);
      end
      o_gnt_vld = |w_elig;
      o_gnt_id  = 1'b0;
      case (w_elig)
         2'b01:   o_gnt_id = 1'b0;
         2'b10:   o_gnt_id = 1'b1;
         2'b11:   o_gnt_id = ~i_last;
         default: o_gnt_id = 1'b0;
      endcase
   end

endmodule

// File: rtl/bios_port_arbiter.sv
// Arbitrates two requesters onto one single-port synchronous memory.
// Each access takes IDLE -> ACC (ce pulse) -> RESP (read data returns) and
// acks the owner on the way back to IDLE. A requester holding lock at its
// ack keeps exclusive access until it is seen idle-side with lock dropped.
module bios_port_arbiter
   import bios_arb_pkg::*;
#(
   parameter int ADDR_W = ARB_ADDR_W,
   parameter int DATA_W = ARB_DATA_W
) (
   input  logic              cpu_clk,
   input  logic              cpu_reset_n,
   input  logic [ADDR_W-1:0] c0_addr_i,
   input  logic              c0_oe_i,
   input  logic              c0_we_i,
   input  logic [DATA_W-1:0] c0_data_i,
   input  logic              c0_lock_i,
   output logic              c0_ack_o,
   output logic [DATA_W-1:0] c0_data_o,
   input  logic [ADDR_W-1:0] c1_addr_i,
   input  logic              c1_oe_i,
   input  logic              c1_we_i,
   input  logic [DATA_W-1:0] c1_data_i,
   input  logic              c1_lock_i,
   output logic              c1_ack_o,
   output logic [DATA_W-1:0] c1_data_o,
   output logic              mem_ce_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic [1:0]        owner_o
);

   arb_state_t        r_state;
   logic              r_ce;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [1:0]        r_owner;
   logic              r_c0_ack;
   logic              r_c1_ack;
   logic [DATA_W-1:0] r_c0_data;
   logic [DATA_W-1:0] r_c1_data;
   logic              r_cur_id;
   logic              r_cur_wr;
   logic              r_last;
   logic              r_lock;
   logic              r_lock_id;

   logic [1:0]        w_req;
   logic [1:0]        w_req_elig;
   logic [1:0]        w_lock_in;
   logic              w_lock_en;
   logic              w_gnt_vld;
   logic              w_gnt_id;
   logic              w_win_we;
   logic [ADDR_W-1:0] w_win_addr;
   logic [DATA_W-1:0] w_win_data;

   // A requester being acked this cycle is masked so a held request is not re-granted
   assign w_req      = {c1_oe_i | c1_we_i, c0_oe_i | c0_we_i};
   assign w_req_elig = w_req & ~{r_c1_ack, r_c0_ack};
   assign w_lock_in  = {c1_lock_i, c0_lock_i};
   // Lock only restricts arbitration while its holder still asserts lock_i
   assign w_lock_en  = r_lock & w_lock_in[r_lock_id];

   arb_rr2 u_rr (
      .i_req     (w_req_elig),
      .i_lock_en (w_lock_en),
      .i_lock_id (r_lock_id),
      .i_last    (r_last),
      .o_gnt_vld (w_gnt_vld),
      .o_gnt_id  (w_gnt_id)
   );

   assign w_win_we   = w_gnt_id ? c1_we_i   : c0_we_i;
   assign w_win_addr = w_gnt_id ? c1_addr_i : c0_addr_i;
   assign w_win_data = w_gnt_id ? c1_data_i : c0_data_i;

   // Access sequencer: grant in IDLE, strobe memory in ACC, ack and capture in RESP
   always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
      if (!cpu_reset_n) begin
         r_state   <= ST_IDLE;
         r_ce      <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_owner   <= 2'b00;
         r_c0_ack  <= 1'b0;
         r_c1_ack  <= 1'b0;
         r_c0_data <= '0;
         r_c1_data <= '0;
         r_cur_id  <= 1'b0;
         r_cur_wr  <= 1'b0;
         r_last    <= 1'b1;
         r_lock    <= 1'b0;
         r_lock_id <= 1'b0;
      end else begin
         r_c0_ack <= 1'b0;
         r_c1_ack <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_lock && !w_lock_in[r_lock_id]) begin
                  r_lock <= 1'b0;
               end
               if (w_gnt_vld) begin
                  r_state  <= ST_ACC;
                  r_ce     <= 1'b1;
                  r_we     <= w_win_we;
                  r_addr   <= w_win_addr;
                  r_wdata  <= w_win_data;
                  r_owner  <= w_gnt_id ? 2'b10 : 2'b01;
                  r_cur_id <= w_gnt_id;
                  r_cur_wr <= w_win_we;
                  r_last   <= w_gnt_id;
               end
            end
            ST_ACC: begin
               r_state <= ST_RESP;
               r_ce    <= 1'b0;
               r_we    <= 1'b0;
            end
            ST_RESP: begin
               r_state   <= ST_IDLE;
               r_owner   <= 2'b00;
               r_lock    <= w_lock_in[r_cur_id];
               r_lock_id <= r_cur_id;
               if (r_cur_id) begin
                  r_c1_ack <= 1'b1;
                  if (!r_cur_wr) r_c1_data <= mem_data_i;
               end else begin
                  r_c0_ack <= 1'b1;
                  if (!r_cur_wr) r_c0_data <= mem_data_i;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_ce    <= 1'b0;
               r_we    <= 1'b0;
               r_owner <= 2'b00;
            end
         endcase
      end
   end

   assign mem_ce_o   = r_ce;
   assign mem_we_o   = r_we;
   assign mem_addr_o = r_addr;
   assign mem_data_o = r_wdata;
   assign owner_o    = r_owner;
   assign c0_ack_o   = r_c0_ack;
   assign c1_ack_o   = r_c1_ack;
   assign c0_data_o  = r_c0_data;
   assign c1_data_o  = r_c1_data;

endmodule

// File: tb/tb_bios_port_arbiter.sv
// Randomized and directed bench for bios_port_arbiter against a
// transaction-level reference model with its own memory image.
module tb_bios_port_arbiter;

   logic        cpu_clk = 1'b0;
   logic        cpu_reset_n;
   logic [10:0] c0_addr_i, c1_addr_i;
   logic        c0_oe_i, c0_we_i, c0_lock_i, c1_oe_i, c1_we_i, c1_lock_i;
   logic [7:0]  c0_data_i, c1_data_i;
   logic        c0_ack_o, c1_ack_o;
   logic [7:0]  c0_data_o, c1_data_o;
   logic        mem_ce_o, mem_we_o;
   logic [10:0] mem_addr_o;
   logic [7:0]  mem_data_o;
   logic [7:0]  mem_rdata;
   logic [1:0]  owner_o;

   int n_cmp;
   int n_err;

   bios_port_arbiter u_dut (
      .cpu_clk     (cpu_clk),
      .cpu_reset_n (cpu_reset_n),
      .c0_addr_i   (c0_addr_i),
      .c0_oe_i     (c0_oe_i),
      .c0_we_i     (c0_we_i),
      .c0_data_i   (c0_data_i),
      .c0_lock_i   (c0_lock_i),
      .c0_ack_o    (c0_ack_o),
      .c0_data_o   (c0_data_o),
      .c1_addr_i   (c1_addr_i),
      .c1_oe_i     (c1_oe_i),
      .c1_we_i     (c1_we_i),
      .c1_data_i   (c1_data_i),
      .c1_lock_i   (c1_lock_i),
      .c1_ack_o    (c1_ack_o),
      .c1_data_o   (c1_data_o),
      .mem_ce_o    (mem_ce_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_data_o  (mem_data_o),
      .mem_data_i  (mem_rdata),
      .owner_o     (owner_o)
   );

   always #5 cpu_clk = ~cpu_clk;

   function automatic logic [7:0] init_val(input logic [10:0] a);
      return a[7:0] ^ 8'h86;
   endfunction

   // Behavioural single-port synchronous memory seen by the DUT
   logic [7:0] dut_mem [0:2047];
   initial begin
      for (int i = 0; i < 2048; i++) dut_mem[i] <= init_val(11'(i));
   end
   always @(posedge cpu_clk) begin
      if (mem_ce_o) begin
         if (mem_we_o) dut_mem[mem_addr_o] <= mem_data_o;
         else          mem_rdata <= dut_mem[mem_addr_o];
      end
   end

   // Reference model: phase 0 = free, 1 = memory strobe cycle, 2 = response cycle
   logic [7:0]  ref_mem [0:2047];
   int          m_phase;
   logic        m_cur, m_last, m_wr, m_lock, m_lockid;
   logic [10:0] m_addr;
   logic [7:0]  m_wdata;
   logic [1:0]  m_ack;
   logic [7:0]  m_dout [0:1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic lock_of(input logic id);
      return id ? c1_lock_i : c0_lock_i;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_cur = 1'b0; m_last = 1'b1; m_wr = 1'b0;
      m_lock = 1'b0; m_lockid = 1'b0; m_addr = '0; m_wdata = '0;
      m_ack = 2'b00; m_dout[0] = '0; m_dout[1] = '0;
   endtask

   task automatic model_edge();
      logic [1:0] want;
      logic [1:0] nxt_ack;
      want[0] = (c0_oe_i | c0_we_i) & ~m_ack[0];
      want[1] = (c1_oe_i | c1_we_i) & ~m_ack[1];
      nxt_ack = 2'b00;
      if (m_phase == 0) begin
         if (m_lock && !lock_of(m_lockid)) m_lock = 1'b0;
         if (m_lock) want[~m_lockid] = 1'b0;
         if (want != 2'b00) begin
            if (want == 2'b11) m_cur = (m_last == 1'b0);
            else               m_cur = want[1];
            m_last  = m_cur;
            m_phase = 1;
            m_wr    = m_cur ? c1_we_i   : c0_we_i;
            m_addr  = m_cur ? c1_addr_i : c0_addr_i;
            m_wdata = m_cur ? c1_data_i : c0_data_i;
         end
      end else if (m_phase == 1) begin
         m_phase = 2;
         if (m_wr) ref_mem[m_addr] = m_wdata;
      end else begin
         m_phase = 0;
         nxt_ack[m_cur] = 1'b1;
         if (!m_wr) m_dout[m_cur] = ref_mem[m_addr];
         m_lock   = lock_of(m_cur);
         m_lockid = m_cur;
      end
      m_ack = nxt_ack;
   endtask

   task automatic check_outputs(input string p);
      logic e_ce;
      e_ce = (m_phase == 1);
      chk({p, "_ce"},    32'(mem_ce_o),   32'(e_ce));
      chk({p, "_we"},    32'(mem_we_o),   32'(e_ce & m_wr));
      chk({p, "_addr"},  32'(mem_addr_o), 32'(m_addr));
      chk({p, "_wdata"}, 32'(mem_data_o), 32'(m_wdata));
      chk({p, "_owner"}, 32'(owner_o),    (m_phase != 0) ? (m_cur ? 32'd2 : 32'd1) : 32'd0);
      chk({p, "_ack0"},  32'(c0_ack_o),   32'(m_ack[0]));
      chk({p, "_ack1"},  32'(c1_ack_o),   32'(m_ack[1]));
      chk({p, "_d0"},    32'(c0_data_o),  32'(m_dout[0]));
      chk({p, "_d1"},    32'(c1_data_o),  32'(m_dout[1]));
      chk({p, "_dual"},  32'(c0_ack_o & c1_ack_o), 32'd0);
   endtask

   // One clock: predict, clock, optionally pulse reset just after the edge, check
   task automatic cycle(input bit do_rst);
      if (cpu_reset_n) model_edge();
      @(posedge cpu_clk);
      if (do_rst) begin
         #2 cpu_reset_n = 1'b0;
         #1 model_reset();
         check_outputs("arst");
      end
      @(negedge cpu_clk);
      check_outputs("cyc");
      if (do_rst) cpu_reset_n = 1'b1;
   endtask

   task automatic idle_inputs();
      c0_oe_i = 0; c0_we_i = 0; c0_lock_i = 0; c0_addr_i = '0; c0_data_i = '0;
      c1_oe_i = 0; c1_we_i = 0; c1_lock_i = 0; c1_addr_i = '0; c1_data_i = '0;
   endtask

   int          ackq [$];
   int          ackt [$];
   int          g0;
   int          acks;
   logic [7:0]  d1_keep;

   initial begin
      n_cmp = 0; n_err = 0;
      for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(11'(i));
      idle_inputs();
      cpu_reset_n = 1'b0;
      model_reset();
      @(negedge cpu_clk);
      check_outputs("reset");
      cpu_reset_n = 1'b1;

      // c0 read of 0x123, request dropped after grant
      c0_oe_i = 1; c0_addr_i = 11'h123;
      cycle(0);
      chk("s1_ce", 32'(mem_ce_o), 32'd1);
      chk("s1_owner", 32'(owner_o), 32'd1);
      chk("s1_addr", 32'(mem_addr_o), 32'h123);
      c0_oe_i = 0;
      cycle(0);
      chk("s1_ce_off", 32'(mem_ce_o), 32'd0);
      cycle(0);
      chk("s1_ack", 32'(c0_ack_o), 32'd1);
      chk("s1_data", 32'(c0_data_o), 32'hA5);
      cycle(0);
      chk("s1_ack_off", 32'(c0_ack_o), 32'd0);

      // Both held from reset: alternate grants, acks 3 cycles apart
      cycle(1);
      c0_oe_i = 1; c0_addr_i = 11'h010; c1_oe_i = 1; c1_addr_i = 11'h020;
      for (int i = 1; i <= 12; i++) begin
         cycle(0);
         if (c0_ack_o) begin ackq.push_back(0); ackt.push_back(i); end
         if (c1_ack_o) begin ackq.push_back(1); ackt.push_back(i); end
      end
      chk("s2_count", 32'(ackq.size()), 32'd4);
      for (int k = 0; k < ackq.size() && k < 4; k++) begin
         chk("s2_order", 32'(ackq[k]), 32'(k % 2));
         chk("s2_time", 32'(ackt[k]), 32'(3 * (k + 1)));
      end
      idle_inputs();
      repeat (4) cycle(0);

      // c1 write with oe also set
      d1_keep = c1_data_o;
      c1_we_i = 1; c1_oe_i = 1; c1_addr_i = 11'h7FF; c1_data_i = 8'h5A;
      cycle(0);
      chk("s3_we", 32'(mem_we_o), 32'd1);
      chk("s3_addr", 32'(mem_addr_o), 32'h7FF);
      chk("s3_data", 32'(mem_data_o), 32'h5A);
      idle_inputs();
      cycle(0);
      cycle(0);
      chk("s3_ack", 32'(c1_ack_o), 32'd1);
      chk("s3_keep", 32'(c1_data_o), 32'(d1_keep));
      cycle(0);

      // c0 locks for three reads while c1 waits
      cycle(1);
      ackq.delete();
      g0 = 0;
      c0_oe_i = 1; c0_lock_i = 1; c0_addr_i = 11'h044; c1_oe_i = 1; c1_addr_i = 11'h055;
      for (int i = 0; i < 20; i++) begin
         cycle(0);
         if (c0_ack_o) ackq.push_back(0);
         if (c1_ack_o) ackq.push_back(1);
         if (mem_ce_o && owner_o == 2'b01) g0++;
         if (g0 >= 3) c0_lock_i = 0;
      end
      chk("s4_count_ge4", 32'(ackq.size() >= 4), 32'd1);
      for (int k = 0; k < ackq.size() && k < 4; k++)
         chk("s4_order", 32'(ackq[k]), (k == 3) ? 32'd1 : 32'd0);
      idle_inputs();
      repeat (4) cycle(0);

      // Reset during ACC aborts the access, then a clean c1 read
      c0_oe_i = 1; c0_addr_i = 11'h0AA;
      cycle(1);
      chk("s5_ce", 32'(mem_ce_o), 32'd0);
      chk("s5_owner", 32'(owner_o), 32'd0);
      idle_inputs();
      acks = 0;
      repeat (4) begin
         cycle(0);
         acks += int'(c0_ack_o) + int'(c1_ack_o);
      end
      chk("s5_noack", 32'(acks), 32'd0);
      c1_oe_i = 1; c1_addr_i = 11'h300;
      cycle(0);
      c1_oe_i = 0;
      cycle(0);
      cycle(0);
      chk("s5_ack1", 32'(c1_ack_o), 32'd1);
      chk("s5_d1", 32'(c1_data_o), 32'(init_val(11'h300)));

      // Randomized traffic with occasional locks and resets
      for (int i = 0; i < 3000; i++) begin
         c0_oe_i   = ($urandom_range(0, 1) == 0);
         c0_we_i   = ($urandom_range(0, 3) == 0);
         c0_lock_i = ($urandom_range(0, 5) == 0);
         c0_addr_i = 11'($urandom_range(0, 2047));
         c0_data_i = 8'($urandom);
         c1_oe_i   = ($urandom_range(0, 1) == 0);
         c1_we_i   = ($urandom_range(0, 3) == 0);
         c1_lock_i = ($urandom_range(0, 5) == 0);
         c1_addr_i = 11'($urandom_range(0, 2047));
         c1_data_i = 8'($urandom);
         cycle($urandom_range(0, 199) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bios_port_arbiter.md
BIOS_PORT_ARBITER -- requirements
Module: bios_port_arbiter

Interface
Parameters:
REQ-001 The block SHALL have parameter ADDR_W, default 11, the memory word address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, the data width.
Ports (N = 0, 1; one set per requester):
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 cpu_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 cpu_reset_n  in  1  asynchronous active-low reset.
REQ-006 cN_addr_i  in  ADDR_W  requester N address.
REQ-007 cN_oe_i  in  1  requester N read request.
REQ-008 cN_we_i  in  1  requester N write request.
REQ-009 cN_data_i  in  DATA_W  requester N write data.
REQ-010 cN_lock_i  in  1  requester N asks to keep ownership across accesses.
REQ-011 cN_ack_o  out  1  one-cycle completion pulse for requester N.
REQ-012 cN_data_o  out  DATA_W  read data for requester N, held until its next read ack.
REQ-013 mem_ce_o / mem_we_o  out  1 / 1  single-port memory clock enable / write enable.
REQ-014 mem_addr_o / mem_data_o  out  ADDR_W / DATA_W  memory address / write data.
REQ-015 mem_data_i  in  DATA_W  memory read data, valid the cycle after the ce edge.
REQ-016 owner_o  out  2  bit N set while requester N owns the memory.

Function
REQ-017 reqN = cN_oe_i | cN_we_i; if both are set, the access SHALL be a write.
REQ-018 FSM states: IDLE, ACC, RESP; IDLE->ACC on grant, ACC->RESP unconditionally, RESP->IDLE unconditionally.
REQ-019 In IDLE, a single active request SHALL be granted; with two, the requester not granted last SHALL win.
REQ-020 At the grant edge, mem_addr_o, mem_data_o, mem_we_o and owner_o SHALL be registered from the winner, and mem_ce_o SHALL be 1 for exactly the ACC cycle.
REQ-021 At the RESP->IDLE edge, cN_ack_o SHALL be set for one cycle; on reads, cN_data_o SHALL load mem_data_i at the same edge.
REQ-022 Latency: a request sampled at edge E0 SHALL produce ack high in the cycle after edge E2 (3 cycles), with no back-to-back grants closer than 3 cycles.
REQ-023 A requester's request SHALL be ignored in the cycle its ack is high, so a held request is not granted twice.
REQ-024 Dropping a request after grant SHALL NOT abort the access; the ack SHALL still be issued.
REQ-025 Lock: if the owner's cN_lock_i is 1 at its ack edge, only that requester SHALL be grantable until it is seen in IDLE with lock_i=0; a locked IDLE with the owner idle SHALL grant nobody.
REQ-026 The round-robin pointer SHALL update on every grant, including locked grants.
REQ-027 mem_we_o SHALL be 0 whenever mem_ce_o is 0.

Reset
REQ-028 On cpu_reset_n low, the block SHALL immediately force state IDLE, all outputs 0, lock released, and the pointer set so c0 wins the first tie.
REQ-029 Reset mid-access SHALL abort the access with no ack; the first access after release SHALL start from IDLE.

Structure
REQ-030 Package bios_arb_pkg SHALL hold the state encoding (IDLE=0, ACC=1, RESP=2) and the ADDR_W/DATA_W defaults.
REQ-031 One sub-module, arb_rr2, SHALL compute the 2-way round-robin pick with lock mask; everything else SHALL be in the top.

Verification
REQ-032 Reset release, c0 read addr 0x123, memory returns 0xA5 -> mem_ce_o high cycle 1, c0_ack_o cycle 3, c0_data_o=0xA5, owner_o=01 during access.
REQ-033 c0 and c1 request together from reset and are held -> grant order c0,c1,c0,c1 with acks 3 cycles apart, never both acks in one cycle.
REQ-034 c1 write 0x5A to 0x7FF with oe also set -> mem_we_o=1, mem_addr_o=0x7FF, mem_data_o=0x5A; c1_data_o unchanged.
REQ-035 c0 holds lock for 3 reads while c1 requests -> c1 waits; c1 is granted in the first IDLE after c0 drops lock.
REQ-036 Reset pulsed during ACC -> outputs 0 asynchronously, no ack; a new c1 read completes normally in 3 cycles.
